state_seq_monitor: RTL and testbench
====================================

Name: state_seq_monitor

Overview:
- Downstream consumer of the 3-state sequencer output (IDLE=00, S1=01, S2=10).
- Samples the sequencer's state code every clock and checks that the sequence is legal.
- For each completed IDLE->S1->S2->IDLE round, it measures how many cycles the sequencer spent in S1 and in S2, and counts completed rounds.
- Illegal transitions are reported through a sticky error; the monitor then resynchronises on the next IDLE.

Parameters:
- CNT_W, 8, width of the dwell counters and of s1_len/s2_len; counters saturate at 2^CNT_W-1.
- RND_W, 16, width of round_cnt; wraps modulo 2^RND_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- state_c  input  2  sequencer current-state code, synchronous to clk.
- err_clr  input  1  single-cycle pulse; clears err and err_code.
- round_done  output  1  one-cycle pulse when a legal round completes.
- s1_len  output  CNT_W  S1 dwell (cycles) of the last completed round.
- s2_len  output  CNT_W  S2 dwell (cycles) of the last completed round.
- round_cnt  output  RND_W  number of completed legal rounds.
- err  output  1  sticky sequence-error flag.
- err_code  output  2  cause of the first error since the last clear.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - state_q=IDLE, dwell=0, s1_hold=0, mon=M_IDLE.
  - round_done=0, s1_len=0, s2_len=0, round_cnt=0, err=0, err_code=00.
- state_q: register holding the previous cycle's state_c. A change is flagged when chg = (state_c != state_q).
- dwell counter:
  - chg -> dwell<=1.
  - No change -> dwell<=dwell+1, saturating at all-ones.
  - In a chg cycle, dwell equals the number of cycles state_q was held.
- Monitor FSM, states M_IDLE, M_S1, M_S2, M_RESYNC:
  - M_IDLE: state_c=S1 -> M_S1. Any other change -> error.
  - M_S1: state_c=S2 -> s1_hold<=dwell, go M_S2. Any other change -> error.
  - M_S2: state_c=IDLE -> s1_len<=s1_hold, s2_len<=dwell, round_done<=1, round_cnt<=round_cnt+1 (wraps), go M_IDLE. Any other change -> error.
  - M_RESYNC: stay until state_c=IDLE is sampled, then go M_IDLE. No round_done is issued; the partial round is discarded.
- Error detection is evaluated in M_IDLE, M_S1 and M_S2 only:
  - state_c=11 in any of those states -> code 11 (illegal encoding); takes priority over the transition codes.
  - IDLE->S2 -> code 01 (skip).
  - S1->IDLE or S2->S1 -> code 10 (backward).
  - On any error: err<=1 and FSM goes to M_RESYNC. err_code is loaded only if err was 0, so the first cause is kept.
  - State 11 while already in M_RESYNC does not update err_code.
- err_clr: clears err and err_code next cycle. If a new error is detected in the same cycle, the error wins (err=1, err_code=new cause).
- Latency: round_done, s1_len, s2_len and round_cnt update on the clock edge after state_c is first sampled as IDLE following S2 (1 cycle). round_done is high for exactly 1 cycle.
- Zero-length dwell is impossible: the minimum dwell is 1.
- Saturated dwell values are reported as all-ones; this is not an error.
- Asserting rst mid-round aborts the round. Outputs return to reset values and monitoring restarts in M_IDLE.

Decomposition:
- Shared package:
  - State encodings IDLE/S1/S2 and illegal 2'b11, shared with the sequencer.
  - err_code constants ERR_SKIP=01, ERR_BACK=10, ERR_ENC=11.
  - Monitor FSM encoding.
- One natural sub-module: sat_counter (CNT_W-wide, load-1 / increment with saturation), used for dwell.

Test Plan:
- Sequencer driven with en=1 continuously after reset release: round_done every 13 cycles, s1_len=5, s2_len=7, round_cnt 1,2,3..., err=0.
- en toggling 1,0 alternately: s1_len=9, s2_len=13, no error.
- Force state_c IDLE->S2: err=1, err_code=01. Follow with S2->S1 (backward): err_code stays 01. No round_done until IDLE, then a legal round gives round_done with correct lengths.
- Force state_c=11 in M_S1: err_code=11. Pulse err_clr in the same cycle as a new S2->S1 error: err stays 1, err_code=10.
- Hold S1 for 300 cycles with CNT_W=8: s1_len=255 after round completion. Separately, preload round_cnt near wrap (RND_W=4, run 16 rounds): round_cnt wraps to 0.
- Assert rst while in M_S2: all outputs go to 0 immediately. The next legal round is measured correctly from a fresh IDLE.

Source files
------------

// File: rtl/state_seq_monitor_pkg.sv
// Shared encodings for the 3-state sequencer and its monitor.
// State codes, error causes and monitor FSM states.
package state_seq_monitor_pkg;

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_S1   = 2'b01;
   localparam logic [1:0] ST_S2   = 2'b10;
   localparam logic [1:0] ST_ENC  = 2'b11;

   localparam logic [1:0] ERR_NONE = 2'b00;
   localparam logic [1:0] ERR_SKIP = 2'b01;
   localparam logic [1:0] ERR_BACK = 2'b10;
   localparam logic [1:0] ERR_ENC  = 2'b11;

   typedef enum logic [1:0] {
      M_IDLE,
      M_S1,
      M_S2,
      M_RESYNC
   } mon_t;

endpackage

// File: rtl/state_seq_monitor_if.sv
// Bundle between the sequencer side and the sequence monitor.
// master drives the state code; slave reports rounds and errors.
interface state_seq_monitor_if #(
   parameter int CNT_W = 8,
   parameter int RND_W = 16
);

   logic [1:0]       state_c;
   logic             err_clr;
   logic             round_done;
   logic [CNT_W-1:0] s1_len;
   logic [CNT_W-1:0] s2_len;
   logic [RND_W-1:0] round_cnt;
   logic             err;
   logic [1:0]       err_code;

   modport master (
      output state_c, err_clr,
      input  round_done, s1_len, s2_len,
      input  round_cnt, err, err_code
   );

   modport slave (
      input  state_c, err_clr,
      output round_done, s1_len, s2_len,
      output round_cnt, err, err_code
   );

endinterface

// File: rtl/state_seq_monitor_sat_counter.sv
// Dwell counter: load 1 on a state change, else count up
// and stick at all-ones.
module state_seq_monitor_sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (load)
         cnt <= W'(1);
      else if (cnt != '1)
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/state_seq_monitor.sv
// Checks IDLE->S1->S2->IDLE rounds, measures S1/S2 dwell,
// counts rounds and latches the first sequence error.
module state_seq_monitor #(
   parameter int CNT_W = 8,
   parameter int RND_W = 16
) (
   input logic                clk,
   input logic                rst,
   state_seq_monitor_if.slave bus
);

   import state_seq_monitor_pkg::*;

   logic [1:0]       state_q;
   logic             chg;
   logic [CNT_W-1:0] dwell;
   logic [CNT_W-1:0] s1_hold;
   logic [CNT_W-1:0] s1_hold_d;
   mon_t             mon;
   mon_t             mon_d;
   logic             done_d;
   logic             err_hit;
   logic [1:0]       err_cause;

   assign chg = (bus.state_c != state_q);

   state_seq_monitor_sat_counter #(
      .W(CNT_W)
   ) u_dwell (
      .clk (clk),
      .rst (rst),
      .load(chg),
      .cnt (dwell)
   );

   always_comb begin
      mon_d     = mon;
      s1_hold_d = s1_hold;
      done_d    = 1'b0;
      err_hit   = 1'b0;
      err_cause = ERR_NONE;
      unique case (mon)
         M_IDLE:
            if (chg) begin
               if (bus.state_c == ST_S1) begin
                  mon_d = M_S1;
               end else begin
                  err_hit   = 1'b1;
                  err_cause = ERR_SKIP;
               end
            end
         M_S1:
            if (chg) begin
               if (bus.state_c == ST_S2) begin
                  s1_hold_d = dwell;
                  mon_d     = M_S2;
               end else begin
                  err_hit   = 1'b1;
                  err_cause = ERR_BACK;
               end
            end
         M_S2:
            if (chg) begin
               if (bus.state_c == ST_IDLE) begin
                  done_d = 1'b1;
                  mon_d  = M_IDLE;
               end else begin
                  err_hit   = 1'b1;
                  err_cause = ERR_BACK;
               end
            end
         M_RESYNC:
            if (bus.state_c == ST_IDLE)
               mon_d = M_IDLE;
      endcase
      // A bad encoding outranks whatever transition it mimics
      if (err_hit) begin
         mon_d = M_RESYNC;
         if (bus.state_c == ST_ENC)
            err_cause = ERR_ENC;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         mon            <= M_IDLE;
         s1_hold        <= '0;
         bus.round_done <= 1'b0;
         bus.s1_len     <= '0;
         bus.s2_len     <= '0;
         bus.round_cnt  <= '0;
         bus.err        <= 1'b0;
         bus.err_code   <= ERR_NONE;
      end else begin
         state_q        <= bus.state_c;
         mon            <= mon_d;
         s1_hold        <= s1_hold_d;
         bus.round_done <= done_d;
         if (done_d) begin
            bus.s1_len    <= s1_hold;
            bus.s2_len    <= dwell;
            bus.round_cnt <= bus.round_cnt + 1'b1;
         end
         if (err_hit) begin
            bus.err <= 1'b1;
            if (!bus.err || bus.err_clr)
               bus.err_code <= err_cause;
         end else if (bus.err_clr) begin
            bus.err      <= 1'b0;
            bus.err_code <= ERR_NONE;
         end
      end
   end

endmodule

// File: tb/tb_state_seq_monitor.sv
// Directed bench for state_seq_monitor with a round scoreboard;
// a second RND_W=4 instance shares stimulus to exercise wrap.
module tb_state_seq_monitor;

   import state_seq_monitor_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] state_c;
   logic       err_clr;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      int          s1;
      int          s2;
      logic [15:0] cnt;
   } exp_t;

   exp_t        q[$];
   logic [15:0] exp_cnt = '0;

   always #5 clk = ~clk;

   state_seq_monitor_if #(.CNT_W(8), .RND_W(16)) m_if ();
   state_seq_monitor_if #(.CNT_W(8), .RND_W(4))  w_if ();

   assign m_if.state_c = state_c;
   assign m_if.err_clr = err_clr;
   assign w_if.state_c = state_c;
   assign w_if.err_clr = err_clr;

   state_seq_monitor #(.CNT_W(8), .RND_W(16)) dut (
      .clk(clk),
      .rst(rst),
      .bus(m_if)
   );

   state_seq_monitor #(.CNT_W(8), .RND_W(4)) dut_w (
      .clk(clk),
      .rst(rst),
      .bus(w_if)
   );

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
      end
   endtask

   function automatic int sat(input int n);
      return (n > 255) ? 255 : n;
   endfunction

   task automatic drive(input logic [1:0] s, input int n);
      state_c = s;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic round(input int n1, input int n2);
      exp_t e;
      drive(ST_S1, n1);
      drive(ST_S2, n2);
      exp_cnt = exp_cnt + 16'd1;
      e.s1  = sat(n1);
      e.s2  = sat(n2);
      e.cnt = exp_cnt;
      q.push_back(e);
      drive(ST_IDLE, 1);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_done"}, 32'(m_if.round_done), 0);
      chk({tag, "_s1"}, 32'(m_if.s1_len), 0);
      chk({tag, "_s2"}, 32'(m_if.s2_len), 0);
      chk({tag, "_cnt"}, 32'(m_if.round_cnt), 0);
      chk({tag, "_err"}, 32'(m_if.err), 0);
      chk({tag, "_code"}, 32'(m_if.err_code), 0);
      chk({tag, "_wcnt"}, 32'(w_if.round_cnt), 0);
   endtask

   // Scoreboard: each round_done pops the oldest expected round
   always @(negedge clk) begin
      if (!rst && m_if.round_done) begin
         n_cmp++;
         assert (q.size() != 0) else begin
            n_bad++;
            $error("FAIL unexpected_round: observed 1 expected 0");
         end
         if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk("s1_len", 32'(m_if.s1_len), e.s1);
            chk("s2_len", 32'(m_if.s2_len), e.s2);
            chk("round_cnt", 32'(m_if.round_cnt), 32'(e.cnt));
            chk("w_done", 32'(w_if.round_done), 1);
            chk("w_round_cnt", 32'(w_if.round_cnt),
                32'(e.cnt[3:0]));
         end
      end
   end

   initial begin
      rst     = 1'b1;
      state_c = ST_IDLE;
      err_clr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_zero("reset");
      rst = 1'b0;

      repeat (3) round(5, 7);
      repeat (2) round(9, 13);

      drive(ST_S2, 1);
      chk("skip_err", 32'(m_if.err), 1);
      chk("skip_code", 32'(m_if.err_code), 32'(ERR_SKIP));
      drive(ST_S1, 1);
      chk("keep_first", 32'(m_if.err_code), 32'(ERR_SKIP));
      drive(ST_S2, 2);
      drive(ST_IDLE, 1);
      round(5, 7);
      chk("sticky_err", 32'(m_if.err), 1);

      err_clr = 1'b1;
      drive(ST_IDLE, 1);
      err_clr = 1'b0;
      chk("clr_err", 32'(m_if.err), 0);
      chk("clr_code", 32'(m_if.err_code), 0);

      drive(ST_S1, 3);
      drive(ST_ENC, 1);
      chk("enc_code", 32'(m_if.err_code), 32'(ERR_ENC));
      drive(ST_IDLE, 1);
      drive(ST_S1, 2);
      drive(ST_S2, 2);
      err_clr = 1'b1;
      drive(ST_S1, 1);
      err_clr = 1'b0;
      chk("clr_race_err", 32'(m_if.err), 1);
      chk("clr_race_code", 32'(m_if.err_code), 32'(ERR_BACK));
      drive(ST_ENC, 1);
      chk("resync_enc", 32'(m_if.err_code), 32'(ERR_BACK));
      drive(ST_IDLE, 1);

      err_clr = 1'b1;
      drive(ST_IDLE, 1);
      err_clr = 1'b0;
      drive(ST_S1, 2);
      drive(ST_IDLE, 1);
      chk("s1_idle_code", 32'(m_if.err_code), 32'(ERR_BACK));
      drive(ST_IDLE, 1);
      err_clr = 1'b1;
      drive(ST_IDLE, 1);
      err_clr = 1'b0;
      round(4, 3);

      round(300, 2);
      round(2, 256);

      for (int i = 0; i < 12; i++)
         round(int'($urandom_range(1, 4)),
               int'($urandom_range(1, 4)));

      drive(ST_IDLE, 2);
      chk("pending_a", q.size(), 0);
      chk("no_err", 32'(m_if.err), 0);

      drive(ST_S1, 4);
      drive(ST_S2, 3);
      rst     = 1'b1;
      state_c = ST_IDLE;
      #1;
      chk_zero("mid_rst");
      exp_cnt = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      round(6, 4);

      drive(ST_IDLE, 2);
      chk("pending_b", q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
